// File: rtl/redmule_tcdm_lane_splitter.sv
// Splits the wide RedMulE TCDM port into MP independent 32-bit lanes and
// reassembles one wide grant and one wide response per transaction.
module redmule_tcdm_lane_splitter #(
    parameter int unsigned MP = 8,
    parameter int unsigned DW = 32 * MP
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              w_req_i,
    output logic              w_gnt_o,
    input  logic [31:0]       w_add_i,
    input  logic              w_wen_i,
    input  logic [DW/8-1:0]   w_be_i,
    input  logic [DW-1:0]     w_data_i,
    output logic [DW-1:0]     w_r_data_o,
    output logic              w_r_valid_o,
    output logic [MP-1:0]     n_req_o,
    input  logic [MP-1:0]     n_gnt_i,
    output logic [MP*32-1:0]  n_add_o,
    output logic [MP-1:0]     n_wen_o,
    output logic [MP*4-1:0]   n_be_o,
    output logic [MP*32-1:0]  n_data_o,
    input  logic [MP*32-1:0]  n_r_data_i,
    input  logic [MP-1:0]     n_r_valid_i
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        OUT   = 2'd1,
        BUF   = 2'd2
    } lane_state_e;

    lane_state_e   state_q [MP];
    lane_state_e   state_d [MP];
    logic [31:0]   buf_q   [MP];
    logic [31:0]   buf_d   [MP];
    logic [MP-1:0] sent_q, sent_d;
    logic [MP-1:0] is_out, is_buf, lane_free, lane_gnt;
    logic          fire;
    logic [DW-1:0] rdata_asm;
    logic [DW-1:0] rdata_q;

    for (genvar i = 0; i < MP; i++) begin : g_lane
        assign n_add_o[32*i +: 32]  = w_add_i + 32'(4 * i);
        assign n_be_o[4*i +: 4]     = w_be_i[4*i +: 4];
        assign n_data_o[32*i +: 32] = w_data_i[32*i +: 32];
        assign n_wen_o[i]           = w_wen_i;
        assign is_out[i]            = (state_q[i] == OUT);
        assign is_buf[i]            = (state_q[i] == BUF);
        assign rdata_asm[32*i +: 32] = is_buf[i] ? buf_q[i] : n_r_data_i[32*i +: 32];
    end

    // The wide response issues only once every lane has either buffered or live data.
    assign fire      = &(is_buf | (is_out & n_r_valid_i));
    assign lane_free = ~(is_out | is_buf)
                     | (is_buf & {MP{fire}})
                     | (is_out & n_r_valid_i & {MP{fire}});

    assign n_req_o  = {MP{w_req_i}} & ~sent_q & lane_free;
    assign lane_gnt = n_req_o & n_gnt_i;
    assign w_gnt_o  = w_req_i & (&(sent_q | lane_gnt));
    assign sent_d   = w_gnt_o ? '0 : (sent_q | lane_gnt);

    assign w_r_valid_o = fire;
    assign w_r_data_o  = fire ? rdata_asm : rdata_q;

    always_comb begin
        for (int i = 0; i < MP; i++) begin
            state_d[i] = state_q[i];
            buf_d[i]   = buf_q[i];
            case (state_q[i])
                EMPTY: begin
                    if (lane_gnt[i]) state_d[i] = OUT;
                end
                OUT: begin
                    if (n_r_valid_i[i]) begin
                        if (fire) begin
                            state_d[i] = lane_gnt[i] ? OUT : EMPTY;
                        end else begin
                            state_d[i] = BUF;
                            buf_d[i]   = n_r_data_i[32*i +: 32];
                        end
                    end
                end
                BUF: begin
                    if (fire) state_d[i] = lane_gnt[i] ? OUT : EMPTY;
                end
                default: state_d[i] = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MP; i++) begin
                state_q[i] <= EMPTY;
                buf_q[i]   <= '0;
            end
            sent_q  <= '0;
            rdata_q <= '0;
        end else begin
            for (int i = 0; i < MP; i++) begin
                state_q[i] <= state_d[i];
                buf_q[i]   <= buf_d[i];
            end
            sent_q <= sent_d;
            if (fire) rdata_q <= rdata_asm;
        end
    end

endmodule

// File: tb/tb_redmule_tcdm_lane_splitter.sv
// Bench for redmule_tcdm_lane_splitter: per-lane memory model with programmable
// latency, a wide-response scoreboard and cycle-accurate scenario tasks.
module tb_redmule_tcdm_lane_splitter;

    localparam int unsigned MP = 8;
    localparam int unsigned DW = 32 * MP;

    logic              clk_i;
    logic              rst_ni;
    logic              w_req_i;
    logic              w_gnt_o;
    logic [31:0]       w_add_i;
    logic              w_wen_i;
    logic [DW/8-1:0]   w_be_i;
    logic [DW-1:0]     w_data_i;
    logic [DW-1:0]     w_r_data_o;
    logic              w_r_valid_o;
    logic [MP-1:0]     n_req_o;
    logic [MP-1:0]     n_gnt_i;
    logic [MP*32-1:0]  n_add_o;
    logic [MP-1:0]     n_wen_o;
    logic [MP*4-1:0]   n_be_o;
    logic [MP*32-1:0]  n_data_o;
    logic [MP*32-1:0]  n_r_data_i;
    logic [MP-1:0]     n_r_valid_i;

    int n_checks = 0;
    int n_fail   = 0;

    redmule_tcdm_lane_splitter #(.MP(MP), .DW(DW)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .w_req_i     (w_req_i),
        .w_gnt_o     (w_gnt_o),
        .w_add_i     (w_add_i),
        .w_wen_i     (w_wen_i),
        .w_be_i      (w_be_i),
        .w_data_i    (w_data_i),
        .w_r_data_o  (w_r_data_o),
        .w_r_valid_o (w_r_valid_o),
        .n_req_o     (n_req_o),
        .n_gnt_i     (n_gnt_i),
        .n_add_o     (n_add_o),
        .n_wen_o     (n_wen_o),
        .n_be_o      (n_be_o),
        .n_data_o    (n_data_o),
        .n_r_data_i  (n_r_data_i),
        .n_r_valid_i (n_r_valid_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    function automatic logic [MP*32-1:0] lane_addrs(input logic [31:0] a);
        logic [MP*32-1:0] v;
        for (int i = 0; i < MP; i++) v[32*i +: 32] = a + 32'(4 * i);
        return v;
    endfunction

    // Narrow memory model: one response per grant, 1 + lat_extra cycles later.
    int          cyc = 0;
    int          lat_extra [MP];
    bit          pend      [MP];
    int          due       [MP];
    logic [31:0] pdat      [MP];
    logic [31:0] a_s       [MP];
    logic [MP-1:0] g_s;

    always @(posedge clk_i) begin
        cyc = cyc + 1;
        g_s = n_req_o & n_gnt_i;
        for (int i = 0; i < MP; i++) a_s[i] = n_add_o[32*i +: 32];
        #1;
        for (int i = 0; i < MP; i++) begin
            if (g_s[i]) begin
                pend[i] = 1'b1;
                due[i]  = cyc + lat_extra[i];
                pdat[i] = mem_word(a_s[i]);
            end
            if (pend[i] && due[i] == cyc) begin
                n_r_valid_i[i]          = 1'b1;
                n_r_data_i[32*i +: 32]  = pdat[i];
                pend[i]                 = 1'b0;
            end else begin
                n_r_valid_i[i]          = 1'b0;
                n_r_data_i[32*i +: 32]  = 32'hDEAD_BEEF;
            end
        end
    end

    // Scoreboard: push on wide grant, pop on wide response.
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] push_v;
    logic [DW-1:0] pop_v;

    always @(posedge clk_i) begin
        if (rst_ni && w_req_i && w_gnt_o) begin
            for (int i = 0; i < MP; i++) push_v[32*i +: 32] = mem_word(w_add_i + 32'(4 * i));
            exp_q.push_back(push_v);
        end
    end

    always @(negedge rst_ni) exp_q.delete();

    always @(negedge clk_i) begin
        if (w_r_valid_o === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_resp: got response %h, required none pending", w_r_data_o);
            end else begin
                pop_v = exp_q.pop_front();
                if (w_r_data_o !== pop_v) begin
                    n_fail++;
                    $display("FAIL sb_resp_data: got %h required %h", w_r_data_o, pop_v);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni  = 1'b0;
        w_req_i = 1'b1;
        n_gnt_i = '0;
        @(negedge clk_i);
        n_checks++;
        if (w_gnt_o !== 1'b0) begin n_fail++; $display("FAIL rst_gnt: got %b required 0", w_gnt_o); end
        n_checks++;
        if (w_r_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b required 0", w_r_valid_o); end
        n_checks++;
        if (n_req_o !== {MP{1'b1}}) begin n_fail++; $display("FAIL rst_nreq_hi: got %h required %h", n_req_o, {MP{1'b1}}); end
        w_req_i = 1'b0;
        #1;
        n_checks++;
        if (n_req_o !== '0) begin n_fail++; $display("FAIL rst_nreq_lo: got %h required 0", n_req_o); end
        next_cycle();
        rst_ni  = 1'b1;
        n_gnt_i = '1;
        repeat (2) next_cycle();
    endtask

    task automatic test_no_stall();
        w_wen_i = 1'b1;
        w_be_i  = '1;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                w_req_i  = 1'b1;
                w_add_i  = 32'h1C01_0000 + 32'(32 * k);
                w_data_i = {MP{32'(k)}};
            end else begin
                w_req_i = 1'b0;
            end
            @(negedge clk_i);
            if (k < 4) begin
                n_checks++;
                if (w_gnt_o !== 1'b1) begin n_fail++; $display("FAIL nostall_gnt k=%0d: got %b required 1", k, w_gnt_o); end
                n_checks++;
                if (n_req_o !== {MP{1'b1}}) begin n_fail++; $display("FAIL nostall_nreq k=%0d: got %h required %h", k, n_req_o, {MP{1'b1}}); end
                n_checks++;
                if (n_add_o !== lane_addrs(w_add_i)) begin n_fail++; $display("FAIL nostall_addr k=%0d: got %h required %h", k, n_add_o, lane_addrs(w_add_i)); end
                n_checks++;
                if (n_wen_o !== {MP{1'b1}}) begin n_fail++; $display("FAIL nostall_wen k=%0d: got %h required %h", k, n_wen_o, {MP{1'b1}}); end
            end
            n_checks++;
            if (w_r_valid_o !== (k >= 1 && k <= 4)) begin
                n_fail++; $display("FAIL nostall_rvalid k=%0d: got %b required %b", k, w_r_valid_o, (k >= 1 && k <= 4));
            end
            next_cycle();
        end
    endtask

    task automatic test_grant_stall();
        w_req_i = 1'b1;
        w_wen_i = 1'b1;
        w_add_i = 32'h1C02_0000;
        for (int k = 0; k < 5; k++) begin
            n_gnt_i = (k < 2) ? ~(MP'(1) << 3) : '1;
            if (k == 3) w_req_i = 1'b0;
            @(negedge clk_i);
            if (k <= 2) begin
                n_checks++;
                if (n_req_o !== ((k == 0) ? {MP{1'b1}} : (MP'(1) << 3))) begin
                    n_fail++; $display("FAIL stall_nreq k=%0d: got %h required %h", k, n_req_o, ((k == 0) ? {MP{1'b1}} : (MP'(1) << 3)));
                end
                n_checks++;
                if (w_gnt_o !== (k == 2)) begin n_fail++; $display("FAIL stall_gnt k=%0d: got %b required %b", k, w_gnt_o, (k == 2)); end
            end
            n_checks++;
            if (w_r_valid_o !== (k == 3)) begin n_fail++; $display("FAIL stall_rvalid k=%0d: got %b required %b", k, w_r_valid_o, (k == 3)); end
            next_cycle();
        end
    endtask

    task automatic test_response_skew();
        lat_extra[5] = 3;
        w_wen_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            w_req_i = (k <= 4);
            w_add_i = (k == 0) ? 32'h1C03_0000 : 32'h1C03_0100;
            @(negedge clk_i);
            if (k <= 4) begin
                n_checks++;
                if (w_gnt_o !== (k == 0 || k == 4)) begin n_fail++; $display("FAIL skew_gnt k=%0d: got %b required %b", k, w_gnt_o, (k == 0 || k == 4)); end
            end
            if (k >= 1 && k <= 4) begin
                n_checks++;
                if (n_req_o !== ((k == 4) ? {MP{1'b1}} : {MP{1'b0}})) begin
                    n_fail++; $display("FAIL skew_nreq k=%0d: got %h required %h", k, n_req_o, ((k == 4) ? {MP{1'b1}} : {MP{1'b0}}));
                end
            end
            n_checks++;
            if (w_r_valid_o !== (k == 4 || k == 8)) begin n_fail++; $display("FAIL skew_rvalid k=%0d: got %b required %b", k, w_r_valid_o, (k == 4 || k == 8)); end
            next_cycle();
        end
        lat_extra[5] = 0;
    endtask

    task automatic test_partial_be_wrap();
        int n_valid = 0;
        w_req_i  = 1'b1;
        w_wen_i  = 1'b0;
        w_add_i  = 32'hFFFF_FFF8;
        w_be_i   = (DW/8)'(32'h0000_000F);
        w_data_i = {32'h7777_0007, 32'h6666_0006, 32'h5555_0005, 32'h4444_0004,
                    32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_ABCD};
        for (int k = 0; k < 5; k++) begin
            if (k == 1) w_req_i = 1'b0;
            @(negedge clk_i);
            if (k == 0) begin
                n_checks++;
                if (w_gnt_o !== 1'b1) begin n_fail++; $display("FAIL be_gnt: got %b required 1", w_gnt_o); end
                n_checks++;
                if (n_req_o !== {MP{1'b1}}) begin n_fail++; $display("FAIL be_nreq: got %h required %h", n_req_o, {MP{1'b1}}); end
                n_checks++;
                if (n_be_o[3:0] !== 4'hF) begin n_fail++; $display("FAIL be_lane0: got %h required f", n_be_o[3:0]); end
                n_checks++;
                if (n_be_o[MP*4-1:4] !== '0) begin n_fail++; $display("FAIL be_others: got %h required 0", n_be_o[MP*4-1:4]); end
                n_checks++;
                if (n_add_o[64 +: 32] !== 32'h0000_0000) begin n_fail++; $display("FAIL be_addr_wrap: got %h required 00000000", n_add_o[64 +: 32]); end
                n_checks++;
                if (n_add_o !== lane_addrs(32'hFFFF_FFF8)) begin n_fail++; $display("FAIL be_addr_all: got %h required %h", n_add_o, lane_addrs(32'hFFFF_FFF8)); end
                n_checks++;
                if (n_data_o[31:0] !== 32'h0000_ABCD || n_data_o[255:224] !== 32'h7777_0007) begin
                    n_fail++; $display("FAIL be_data: got %h required lane0 0000abcd lane7 77770007", n_data_o);
                end
                n_checks++;
                if (n_wen_o !== '0) begin n_fail++; $display("FAIL be_wen: got %h required 0", n_wen_o); end
            end
            if (w_r_valid_o === 1'b1) n_valid++;
            next_cycle();
        end
        n_checks++;
        if (n_valid != 1) begin n_fail++; $display("FAIL be_rvalid_count: got %0d required 1", n_valid); end
        w_wen_i = 1'b1;
        w_be_i  = '1;
    endtask

    task automatic test_reset_mid();
        lat_extra[2] = 2;
        w_wen_i = 1'b1;
        w_req_i = 1'b1;
        w_add_i = 32'h1C04_0000;
        @(negedge clk_i);
        n_checks++;
        if (w_gnt_o !== 1'b1) begin n_fail++; $display("FAIL rmid_gnt0: got %b required 1", w_gnt_o); end
        next_cycle();
        w_req_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (w_r_valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_lag_rvalid: got %b required 0", w_r_valid_o); end
        next_cycle();
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (w_gnt_o !== 1'b0) begin n_fail++; $display("FAIL rmid_rst_gnt: got %b required 0", w_gnt_o); end
        n_checks++;
        if (w_r_valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_rst_rvalid: got %b required 0", w_r_valid_o); end
        next_cycle();
        rst_ni = 1'b1;
        lat_extra[2] = 0;
        for (int k = 3; k <= 4; k++) begin
            @(negedge clk_i);
            n_checks++;
            if (w_r_valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_late_rvalid k=%0d: got %b required 0", k, w_r_valid_o); end
            next_cycle();
        end
        w_req_i = 1'b1;
        w_add_i = 32'h1C05_0040;
        @(negedge clk_i);
        n_checks++;
        if (w_gnt_o !== 1'b1) begin n_fail++; $display("FAIL rmid_new_gnt: got %b required 1", w_gnt_o); end
        next_cycle();
        w_req_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (w_r_valid_o !== 1'b1) begin n_fail++; $display("FAIL rmid_new_rvalid: got %b required 1", w_r_valid_o); end
        next_cycle();
    endtask

    task automatic idle(input int n);
        w_req_i = 1'b0;
        repeat (n) next_cycle();
    endtask

    initial begin
        for (int i = 0; i < MP; i++) begin
            lat_extra[i] = 0;
            pend[i]      = 1'b0;
            due[i]       = 0;
            pdat[i]      = '0;
        end
        n_r_valid_i = '0;
        n_r_data_i  = '0;
        w_add_i     = '0;
        w_wen_i     = 1'b1;
        w_be_i      = '1;
        w_data_i    = '0;

        test_reset();
        test_no_stall();
        idle(3);
        test_grant_stall();
        idle(3);
        test_response_skew();
        idle(3);
        test_partial_be_wrap();
        idle(3);
        test_reset_mid();
        idle(4);

        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d pending responses required 0", exp_q.size()); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/redmule_tcdm_lane_splitter.md
# redmule_tcdm_lane_splitter

Splits the RedMulE wide HCI TCDM port (DW = 32·MP bits) into MP independent 32-bit TCDM lanes toward the banked data memory. Each lane is granted and answered independently. The block tracks per-lane progress and reassembles one wide grant and one wide response per transaction, so lanes that stall or skew never corrupt data. It sits directly downstream of the `redmule_complex` `tcdm` port and upstream of the first MP ports of the data-memory interconnect.

## Interface
Parameters:
- `MP`, default 8: number of 32-bit lanes.
- `DW`, default 32·MP: wide data width; must equal 32·MP.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `w_req_i`, in, 1: wide request.
- `w_gnt_o`, out, 1: wide grant.
- `w_add_i`, in, 32: wide byte address, 4-byte aligned.
- `w_wen_i`, in, 1: 1 = read, 0 = write.
- `w_be_i`, in, DW/8: wide byte enables.
- `w_data_i`, in, DW: wide write data.
- `w_r_data_o`, out, DW: wide response data.
- `w_r_valid_o`, out, 1: wide response valid.
- `n_req_o`, out, MP: per-lane request.
- `n_gnt_i`, in, MP: per-lane grant.
- `n_add_o`, out, MP×32: per-lane address.
- `n_wen_o`, out, MP: per-lane wen.
- `n_be_o`, out, MP×4: per-lane byte enables.
- `n_data_o`, out, MP×32: per-lane write data.
- `n_r_data_i`, in, MP×32: per-lane response data.
- `n_r_valid_i`, in, MP: per-lane response valid.

## Operation
Lane mapping:
- Lane i carries `n_add_o[i] = w_add_i + 4·i` (mod 2^32), `n_be_o[i] = w_be_i[4i+3:4i]`, `n_data_o[i] = w_data_i[32i+31:32i]`, `n_wen_o[i] = w_wen_i`.
- Lane i's response occupies `w_r_data_o[32i+31:32i]` (lane 0 = LSBs).
- All lanes are requested on every transaction, even those whose byte enables are all zero.

Wide-side protocol:
- The master holds `w_req_i` and all payload stable until `w_gnt_o`.
- Narrow memories return exactly one `n_r_valid_i` per granted request, for both reads and writes, in order per lane, with latency ≥ 1 cycle.

Per-lane FSM, states EMPTY / OUT / BUF:
- EMPTY → OUT on a lane grant (`n_req_o[i] & n_gnt_i[i]`).
- OUT → BUF when `n_r_valid_i[i]` arrives and `fire` = 0. Data is captured into the lane buffer.
- OUT → EMPTY when `n_r_valid_i[i]` arrives and `fire` = 1 (live bypass). If the lane is granted in the same cycle, the next state is OUT.
- BUF → EMPTY when `fire` = 1, or BUF → OUT when `fire` = 1 and the lane is re-granted.
- `n_r_valid_i[i]` in EMPTY or BUF is a protocol violation and is ignored.

Lane availability:
- `lane_free[i]` = (EMPTY) | (BUF & `fire`) | (OUT & `n_r_valid_i[i]` & `fire`).
- A lane therefore never holds more than one undelivered response.

Request tracking:
- Mask `sent[MP]` records lanes already granted for the current wide request.
- `n_req_o[i] = w_req_i & ~sent[i] & lane_free[i]`.
- `w_gnt_o = w_req_i & &(sent | (n_req_o & n_gnt_i))`.
- On `w_gnt_o`, `sent` clears. Otherwise `sent |= n_req_o & n_gnt_i`.

Response assembly:
- `fire = &(BUF | (OUT & n_r_valid_i))`.
- `w_r_valid_o = fire`.
- Each lane's data slice is the buffered value in BUF, or the live `n_r_data_i[i]` otherwise.
- `w_r_data_o` holds the last value when `fire` = 0. It is don't-care for the bench.

## Timing
- Reset: all lanes EMPTY, `sent` = 0, buffers = 0. `w_gnt_o` = 0 and `w_r_valid_o` = 0. `n_req_o` equals `w_req_i` replicated across all lanes.
- Grant path is combinational: `n_gnt_i` → `w_gnt_o` in the same cycle. With no stalls, wide grant latency is 0 cycles.
- Response path is combinational: `n_r_valid_i` → `w_r_valid_o` in the same cycle when no lane is lagging.
- With latency-1 memories and no stalls, sustained throughput is 1 wide transaction per cycle.
- A stalled lane delays `w_gnt_o` only. Granted lanes drop `n_req_o` the cycle after their grant and stay quiet until `w_gnt_o`.
- Response skew: early lanes wait in BUF. They accept no new request until `fire`. The wide response issues in the cycle the last lane responds.
- Mid-transaction async reset: all state clears immediately. In-flight narrow responses that arrive after reset land in EMPTY and are ignored.

## Test plan
- **No stall, MP=8.** 4 back-to-back reads at 0x1C010000, 0x1C010020, 0x1C010040, 0x1C010060 with 1-cycle memories → `w_gnt_o` in 4 consecutive cycles. `w_r_valid_o` in cycles 1–4. Lane i addresses are base+4i. Data is lane 0 in the LSBs.
- **Grant stall.** `n_gnt_i[3]` low for cycles 0–1 → lanes ≠3 granted in cycle 0 and `n_req_o` = only bit 3 in cycles 1–2. `w_gnt_o` in cycle 2. `w_r_valid_o` in cycle 3 with lanes ≠3 served from BUF.
- **Response skew.** Lane 5 responds 3 cycles late and a second wide request is pending → `w_r_valid_o` rises in the lane-5 arrival cycle. Lanes ≠5 issue the second request in that same cycle (BUF & `fire`), not earlier.
- **Partial-BE write with address wrap.** `w_be_i` = 0x0000000F, `w_add_i` = 0xFFFFFFF8 → `n_be_o[0]` = 4'hF and all others 0. All 8 lanes are requested. `n_add_o[2]` = 0x00000000. `w_r_valid_o` fires once.
- **Reset mid-operation.** Assert `rst_ni` low while lanes are in OUT/BUF, then release → `w_gnt_o` = 0 and `w_r_valid_o` = 0 immediately. A late `n_r_valid_i` produces no wide response. The next read completes normally.
